stage_mem: RTL and testbench

- MEM pipeline stage. Sits directly downstream of the EX/MEM latch and consumes its register-write fields plus memory-op fields.
- Performs loads and stores over a req/ack data bus and stalls the pipeline while an access is outstanding.
- Aligns load data and drives registered write-back fields to the WB stage.

---
 rtl/stage_mem_pkg.sv | 40 ++++
 rtl/stage_mem_align.sv | 56 +++++
 rtl/stage_mem.sv | 165 ++++++++++++++++
 tb/tb_stage_mem.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared CPU definitions for the MEM stage: memory-op codes, stage states, widths.
package cpu_defines;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic is_mem_op(input mem_op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] offset);
        case (op)
            OP_LH, OP_LHU, OP_SH: return offset[0];
            OP_LW, OP_SW:         return |offset;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_align.sv
// Big-endian lane steering: store byte enables/replication and load extraction/extension.
module mem_align
    import cpu_defines::*;
(
    input  mem_op_e           i_op,
    input  logic [1:0]        i_offset,
    input  logic [XLEN-1:0]   i_store_data,
    input  logic [XLEN-1:0]   i_read_data,
    output logic [3:0]        o_byte_select,
    output logic [XLEN-1:0]   o_store_data,
    output logic [XLEN-1:0]   o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant lane.
    always_comb begin
        w_byte = '0;
        case (i_offset)
            2'd0: w_byte = i_read_data[31:24];
            2'd1: w_byte = i_read_data[23:16];
            2'd2: w_byte = i_read_data[15:8];
            2'd3: w_byte = i_read_data[7:0];
            default: w_byte = '0;
        endcase
        w_half = i_offset[1] ? i_read_data[15:0] : i_read_data[31:16];
    end

    always_comb begin
        o_byte_select = '0;
        o_store_data  = '0;
        o_load_data   = '0;
        case (i_op)
            OP_LB, OP_LBU, OP_SB: o_byte_select = 4'b1000 >> i_offset;
            OP_LH, OP_LHU, OP_SH: o_byte_select = i_offset[1] ? 4'b0011 : 4'b1100;
            OP_LW, OP_SW:         o_byte_select = 4'b1111;
            default:              o_byte_select = '0;
        endcase
        case (i_op)
            OP_SB:   o_store_data = {4{i_store_data[7:0]}};
            OP_SH:   o_store_data = {2{i_store_data[15:0]}};
            OP_SW:   o_store_data = i_store_data;
            default: o_store_data = '0;
        endcase
        case (i_op)
            OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load_data = {24'd0, w_byte};
            OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load_data = {16'd0, w_half};
            OP_LW:   o_load_data = i_read_data;
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: req/ack bus loads/stores with pipeline stall and registered WB fields.
// Optional bus-timeout abort is enabled with `define MEM_TIMEOUT_EN.
module stage_mem
  import cpu_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic                clock,
  input  logic                reset,
  input  logic                mem_register_write_enable,
  input  logic [REG_AW-1:0]   mem_register_write_address,
  input  logic [XLEN-1:0]     mem_register_write_data,
  input  logic [3:0]          mem_memory_operation,
  input  logic [XLEN-1:0]     mem_memory_address,
  input  logic [XLEN-1:0]     mem_memory_store_data,
  output logic                bus_request,
  output logic                bus_write,
  output logic [XLEN-1:0]     bus_address,
  output logic [3:0]          bus_byte_select,
  output logic [XLEN-1:0]     bus_write_data,
  input  logic [XLEN-1:0]     bus_read_data,
  input  logic                bus_ack,
  output logic                stall,
  output logic                wb_register_write_enable,
  output logic [REG_AW-1:0]   wb_register_write_address,
  output logic [XLEN-1:0]     wb_register_write_data,
  output logic                exception_address_error,
  output logic                exception_bus_error
);

  mem_state_e          r_state;
  logic                r_req;
  logic                r_we;
  logic [XLEN-1:0]     r_addr;
  logic [3:0]          r_be;
  logic [XLEN-1:0]     r_wdata;
  logic                r_wb_en;
  logic [REG_AW-1:0]   r_wb_addr;
  logic [XLEN-1:0]     r_wb_data;
  logic                r_addr_err;
  logic                r_bus_err;

  mem_op_e             w_op;
  logic                w_is_mem;
  logic                w_misaligned;
  logic                w_start;
  logic                w_timeout;
  logic [3:0]          w_be;
  logic [XLEN-1:0]     w_store_data;
  logic [XLEN-1:0]     w_load_data;

  assign w_op         = mem_op_e'(mem_memory_operation);
  assign w_is_mem     = is_mem_op(w_op);
  assign w_misaligned = is_misaligned(w_op, mem_memory_address[1:0]);
  assign w_start      = (r_state == ST_IDLE) && w_is_mem && !w_misaligned;

  mem_align u_align (
    .i_op          (w_op),
    .i_offset      (mem_memory_address[1:0]),
    .i_store_data  (mem_memory_store_data),
    .i_read_data   (bus_read_data),
    .o_byte_select (w_be),
    .o_store_data  (w_store_data),
    .o_load_data   (w_load_data)
  );

`ifdef MEM_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Counter holds the number of ack-less BUSY cycles already completed.
  assign w_timeout = (r_state == ST_BUSY) && !bus_ack
                     && (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == ST_BUSY) && !bus_ack) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Gated by reset so an abandoned access releases the pipeline immediately.
  assign stall = reset && (w_start
                 || ((r_state == ST_BUSY) && !bus_ack && !w_timeout));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_is_mem) begin
            r_wb_en   <= mem_register_write_enable;
            r_wb_addr <= mem_register_write_address;
            r_wb_data <= mem_register_write_data;
          end else if (w_misaligned) begin
            r_wb_en    <= 1'b0;
            r_addr_err <= 1'b1;
          end else begin
            r_state <= ST_BUSY;
            r_req   <= 1'b1;
            r_we    <= is_store(w_op);
            r_addr  <= {mem_memory_address[XLEN-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_store_data;
            r_wb_en <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (is_store(w_op)) begin
              r_wb_en <= 1'b0;
            end else begin
              r_wb_en   <= mem_register_write_enable;
              r_wb_addr <= mem_register_write_address;
              r_wb_data <= w_load_data;
            end
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_wb_en   <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_wb_en <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_request               = r_req;
  assign bus_write                 = r_we;
  assign bus_address               = r_addr;
  assign bus_byte_select           = r_be;
  assign bus_write_data            = r_wdata;
  assign wb_register_write_enable  = r_wb_en;
  assign wb_register_write_address = r_wb_addr;
  assign wb_register_write_data    = r_wb_data;
  assign exception_address_error   = r_addr_err;
  assign exception_bus_error       = r_bus_err;

endmodule

// File: tb/tb_stage_mem.sv
// Directed self-checking bench for stage_mem; timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_stage_mem;
  import cpu_defines::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_register_write_enable = 1'b0;
  logic [4:0]  mem_register_write_address = '0;
  logic [31:0] mem_register_write_data = '0;
  logic [3:0]  mem_memory_operation = '0;
  logic [31:0] mem_memory_address = '0;
  logic [31:0] mem_memory_store_data = '0;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = '0;
  logic        bus_ack = 1'b0;
  logic        stall;
  logic        wb_register_write_enable;
  logic [4:0]  wb_register_write_address;
  logic [31:0] wb_register_write_data;
  logic        exception_address_error;
  logic        exception_bus_error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  stage_mem #(.TIMEOUT_CYCLES(4)) u_dut (
    .clock                      (clock),
    .reset                      (reset),
    .mem_register_write_enable  (mem_register_write_enable),
    .mem_register_write_address (mem_register_write_address),
    .mem_register_write_data    (mem_register_write_data),
    .mem_memory_operation       (mem_memory_operation),
    .mem_memory_address         (mem_memory_address),
    .mem_memory_store_data      (mem_memory_store_data),
    .bus_request                (bus_request),
    .bus_write                  (bus_write),
    .bus_address                (bus_address),
    .bus_byte_select            (bus_byte_select),
    .bus_write_data             (bus_write_data),
    .bus_read_data              (bus_read_data),
    .bus_ack                    (bus_ack),
    .stall                      (stall),
    .wb_register_write_enable   (wb_register_write_enable),
    .wb_register_write_address  (wb_register_write_address),
    .wb_register_write_data     (wb_register_write_data),
    .exception_address_error    (exception_address_error),
    .exception_bus_error        (exception_bus_error)
  );

  task automatic test_reset();
    mem_memory_operation = OP_LW;
    mem_memory_address   = 32'h0000_0010;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (bus_request !== 1'b0) begin errors++;
      $display("FAIL reset_req: got %b expected 0", bus_request); end
    checks++; if (bus_write !== 1'b0) begin errors++;
      $display("FAIL reset_write: got %b expected 0", bus_write); end
    checks++; if (bus_address !== 32'h0) begin errors++;
      $display("FAIL reset_addr: got %h expected 0", bus_address); end
    checks++; if (wb_register_write_enable !== 1'b0) begin errors++;
      $display("FAIL reset_wb_en: got %b expected 0", wb_register_write_enable); end
    checks++; if (wb_register_write_address !== 5'd0) begin errors++;
      $display("FAIL reset_wb_addr: got %h expected 0", wb_register_write_address); end
    checks++; if (wb_register_write_data !== 32'h0) begin errors++;
      $display("FAIL reset_wb_data: got %h expected 0", wb_register_write_data); end
    checks++; if (exception_address_error !== 1'b0) begin errors++;
      $display("FAIL reset_addr_err: got %b expected 0", exception_address_error); end
    checks++; if (exception_bus_error !== 1'b0) begin errors++;
      $display("FAIL reset_bus_err: got %b expected 0", exception_bus_error); end
    @(negedge clock);
    mem_memory_operation = OP_NONE;
    reset = 1'b1;
  endtask

  task automatic test_none();
    @(negedge clock);
    mem_memory_operation       = OP_NONE;
    mem_register_write_enable  = 1'b1;
    mem_register_write_address = 5'd5;
    mem_register_write_data    = 32'h0000_1234;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL none_stall: got %b expected 0", stall); end
    @(posedge clock); #1;
    checks++; if (bus_request !== 1'b0) begin errors++;
      $display("FAIL none_req: got %b expected 0", bus_request); end
    checks++; if (wb_register_write_enable !== 1'b1) begin errors++;
      $display("FAIL none_wb_en: got %b expected 1", wb_register_write_enable); end
    checks++; if (wb_register_write_address !== 5'd5) begin errors++;
      $display("FAIL none_wb_addr: got %h expected 05", wb_register_write_address); end
    checks++; if (wb_register_write_data !== 32'h0000_1234) begin errors++;
      $display("FAIL none_wb_data: got %h expected 00001234", wb_register_write_data); end
  endtask

  task automatic run_access(input string name, input logic [3:0] op,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int unsigned delay,
                            input logic exp_wr, input logic [31:0] exp_baddr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic exp_wb_en, input logic [31:0] exp_wb_data);
    int unsigned stalls;
    @(negedge clock);
    mem_memory_operation       = op;
    mem_memory_address         = addr;
    mem_memory_store_data      = sdata;
    mem_register_write_enable  = 1'b1;
    mem_register_write_address = 5'd7;
    mem_register_write_data    = 32'h0BAD_0BAD;
    bus_ack                    = 1'b0;
    bus_read_data              = '0;
    #1;
    stalls = (stall === 1'b1) ? 1 : 0;
    @(posedge clock); #1;
    checks++; if (bus_request !== 1'b1) begin errors++;
      $display("FAIL %s_req: got %b expected 1", name, bus_request); end
    checks++; if (bus_write !== exp_wr) begin errors++;
      $display("FAIL %s_write: got %b expected %b", name, bus_write, exp_wr); end
    checks++; if (bus_address !== exp_baddr) begin errors++;
      $display("FAIL %s_baddr: got %h expected %h", name, bus_address, exp_baddr); end
    checks++; if (bus_byte_select !== exp_be) begin errors++;
      $display("FAIL %s_be: got %b expected %b", name, bus_byte_select, exp_be); end
    if (exp_wr) begin
      checks++; if (bus_write_data !== exp_wdata) begin errors++;
        $display("FAIL %s_wdata: got %h expected %h", name, bus_write_data, exp_wdata); end
    end
    checks++; if (wb_register_write_enable !== 1'b0) begin errors++;
      $display("FAIL %s_bubble: got %b expected 0", name, wb_register_write_enable); end
    for (int unsigned i = 0; i < delay; i++) begin
      @(negedge clock); #1;
      if (stall === 1'b1) stalls++;
      @(posedge clock); #1;
      checks++; if (bus_request !== 1'b1 || bus_byte_select !== exp_be) begin errors++;
        $display("FAIL %s_hold: got req %b be %b expected 1 %b",
                 name, bus_request, bus_byte_select, exp_be); end
    end
    @(negedge clock);
    bus_ack       = 1'b1;
    bus_read_data = rdata;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL %s_ack_stall: got %b expected 0", name, stall); end
    @(posedge clock); #1;
    bus_ack = 1'b0;
    checks++; if (stalls !== delay + 1) begin errors++;
      $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stalls, delay + 1); end
    checks++; if (bus_request !== 1'b0) begin errors++;
      $display("FAIL %s_req_drop: got %b expected 0", name, bus_request); end
    checks++; if (wb_register_write_enable !== exp_wb_en) begin errors++;
      $display("FAIL %s_wb_en: got %b expected %b", name, wb_register_write_enable, exp_wb_en); end
    if (exp_wb_en) begin
      checks++; if (wb_register_write_address !== 5'd7) begin errors++;
        $display("FAIL %s_wb_addr: got %h expected 07", name, wb_register_write_address); end
      checks++; if (wb_register_write_data !== exp_wb_data) begin errors++;
        $display("FAIL %s_wb_data: got %h expected %h", name, wb_register_write_data, exp_wb_data); end
    end
  endtask

  task automatic test_loads();
    run_access("lb",  OP_LB,  32'h101, 32'h0, 32'h11F2_3344, 3, 1'b0, 32'h100, 4'b0100, 32'h0, 1'b1, 32'hFFFF_FFF2);
    run_access("lbu", OP_LBU, 32'h101, 32'h0, 32'h11F2_3344, 3, 1'b0, 32'h100, 4'b0100, 32'h0, 1'b1, 32'h0000_00F2);
    run_access("lh",  OP_LH,  32'h102, 32'h0, 32'h11F2_8344, 0, 1'b0, 32'h100, 4'b0011, 32'h0, 1'b1, 32'hFFFF_8344);
    run_access("lhu", OP_LHU, 32'h100, 32'h0, 32'h11F2_8344, 0, 1'b0, 32'h100, 4'b1100, 32'h0, 1'b1, 32'h0000_11F2);
  endtask

  task automatic test_stores();
    run_access("sh", OP_SH, 32'h202, 32'h0000_ABCD, 32'h0, 1, 1'b1, 32'h200, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'h0);
    run_access("sb", OP_SB, 32'h303, 32'h1234_565A, 32'h0, 0, 1'b1, 32'h300, 4'b0001, 32'h5A5A_5A5A, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_lw", OP_LW, 32'h104, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'h104, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF);
    run_access("b2b_sw", OP_SW, 32'h404, 32'hCAFE_F00D, 32'h0, 2, 1'b1, 32'h404, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);
  endtask

  task automatic test_misaligned(input string name, input logic [3:0] op, input logic [31:0] addr);
    @(negedge clock);
    mem_memory_operation      = op;
    mem_memory_address        = addr;
    mem_register_write_enable = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL %s_stall: got %b expected 0", name, stall); end
    @(posedge clock); #1;
    checks++; if (bus_request !== 1'b0) begin errors++;
      $display("FAIL %s_req: got %b expected 0", name, bus_request); end
    checks++; if (exception_address_error !== 1'b1) begin errors++;
      $display("FAIL %s_exc: got %b expected 1", name, exception_address_error); end
    checks++; if (wb_register_write_enable !== 1'b0) begin errors++;
      $display("FAIL %s_wb_en: got %b expected 0", name, wb_register_write_enable); end
    @(negedge clock);
    mem_memory_operation      = OP_NONE;
    mem_register_write_enable = 1'b0;
    @(posedge clock); #1;
    checks++; if (exception_address_error !== 1'b0) begin errors++;
      $display("FAIL %s_exc_pulse: got %b expected 0", name, exception_address_error); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clock);
    mem_memory_operation       = OP_NONE;
    mem_register_write_enable  = 1'b1;
    mem_register_write_address = 5'd9;
    mem_register_write_data    = 32'h0000_0055;
    @(negedge clock);
    mem_memory_operation = OP_LW;
    mem_memory_address   = 32'h0000_0010;
    @(posedge clock); #1;
    checks++; if (bus_request !== 1'b1 || wb_register_write_address !== 5'd9) begin errors++;
      $display("FAIL rstmid_setup: got req %b wb_addr %h expected 1 09",
               bus_request, wb_register_write_address); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_request !== 1'b0) begin errors++;
      $display("FAIL rstmid_req: got %b expected 0", bus_request); end
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL rstmid_stall: got %b expected 0", stall); end
    checks++; if (wb_register_write_enable !== 1'b0) begin errors++;
      $display("FAIL rstmid_wb_en: got %b expected 0", wb_register_write_enable); end
    checks++; if (wb_register_write_address !== 5'd0) begin errors++;
      $display("FAIL rstmid_wb_addr: got %h expected 0", wb_register_write_address); end
    checks++; if (wb_register_write_data !== 32'h0) begin errors++;
      $display("FAIL rstmid_wb_data: got %h expected 0", wb_register_write_data); end
    @(negedge clock);
    mem_memory_operation      = OP_NONE;
    mem_register_write_enable = 1'b0;
    reset   = 1'b1;
    bus_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL stray_ack_stall: got %b expected 0", stall); end
    @(posedge clock); #1;
    bus_ack = 1'b0;
    checks++; if (bus_request !== 1'b0) begin errors++;
      $display("FAIL stray_ack_req: got %b expected 0", bus_request); end
    checks++; if (wb_register_write_enable !== 1'b0) begin errors++;
      $display("FAIL stray_ack_wb_en: got %b expected 0", wb_register_write_enable); end
    run_access("post_rst_lw", OP_LW, 32'h20, 32'h0, 32'h0102_0304, 0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b1, 32'h0102_0304);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clock);
    mem_memory_operation      = OP_LW;
    mem_memory_address        = 32'h0000_0040;
    mem_register_write_enable = 1'b1;
    bus_ack                   = 1'b0;
    @(posedge clock); #1;
    checks++; if (bus_request !== 1'b1) begin errors++;
      $display("FAIL to_req: got %b expected 1", bus_request); end
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clock); #1;
      checks++; if (stall !== (k < 4)) begin errors++;
        $display("FAIL to_stall_%0d: got %b expected %b", k, stall, (k < 4)); end
      @(posedge clock); #1;
      checks++; if (bus_request !== (k < 4)) begin errors++;
        $display("FAIL to_req_%0d: got %b expected %b", k, bus_request, (k < 4)); end
      checks++; if (exception_bus_error !== (k == 4)) begin errors++;
        $display("FAIL to_exc_%0d: got %b expected %b", k, exception_bus_error, (k == 4)); end
    end
    checks++; if (wb_register_write_enable !== 1'b0) begin errors++;
      $display("FAIL to_wb_en: got %b expected 0", wb_register_write_enable); end
    @(negedge clock);
    mem_memory_operation = OP_NONE;
    @(posedge clock); #1;
    checks++; if (exception_bus_error !== 1'b0) begin errors++;
      $display("FAIL to_exc_pulse: got %b expected 0", exception_bus_error); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_none();
    test_loads();
    test_stores();
    test_back_to_back();
    test_misaligned("mis_lw", OP_LW, 32'h0000_0006);
    test_misaligned("mis_sh", OP_SH, 32'h0000_0201);
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
